// File: rtl/mbist_pkg.sv
// mbist_pkg: FSM state type and the March C- element table used by mem_bist.
//
// Element table (index = element, ops run left to right at each address):
//   E0 up   w0
//   E1 up   r0 w1
//   E2 up   r1 w0
//   E3 down r0 w1
//   E4 down r1 w0
//   E5 up   r0
package mbist_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_CMP,
        S_DONE
    } state_t;

    localparam int NUM_ELEM = 6;
    localparam int ELEM_W   = $clog2(NUM_ELEM);

    localparam logic [ELEM_W-1:0] LAST_ELEM = ELEM_W'(NUM_ELEM - 1);

    // Per element: 1 = addresses walk high-to-low.
    localparam logic [2**ELEM_W-1:0] ELEM_DOWN    = 8'b0001_1000;
    // Per element: 1 = two ops per address, 0 = one op.
    localparam logic [2**ELEM_W-1:0] ELEM_TWO_OPS = 8'b0001_1110;

    // Op list, indexed by {element, op_index}: write flag and background
    // select (0 = B0, 1 = B1). Unused slots read as r0 and are never reached.
    localparam logic [2**(ELEM_W+1)-1:0] OP_IS_WR = 16'b0000_0010_1010_1001;
    localparam logic [2**(ELEM_W+1)-1:0] OP_BG1   = 16'b0000_0001_1001_1000;

endpackage

// File: rtl/mbist_addr_gen.sv
// mbist_addr_gen: loadable up/down address counter for the March walk.
// is_last flags the terminal address for the current direction.
module mbist_addr_gen #(
    parameter int ADDR_WIDTH = 2,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  load,
    input  logic                  load_down,
    input  logic                  step,
    input  logic                  dir_down,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  is_last
);

    localparam logic [ADDR_WIDTH-1:0] TOP_ADDR = ADDR_WIDTH'(DEPTH - 1);

    // Load the start address of a new element, or step one word.
    always_ff @(posedge clk) begin
        if (res) begin
            addr <= '0;
        end else if (load) begin
            addr <= load_down ? TOP_ADDR : '0;
        end else if (step) begin
            addr <= dir_down ? addr - ADDR_WIDTH'(1) : addr + ADDR_WIDTH'(1);
        end
    end

    assign is_last = dir_down ? (addr == '0) : (addr == TOP_ADDR);

endmodule

// File: rtl/mem_bist.sv
// mem_bist: March C- self-test controller driving a memory write/read port.
// Optional build macro MBIST_CHECKERBOARD_EN adds a second March pass with
// an alternating background whose polarity flips on odd addresses.
//
// state  | meaning
// -------+----------------------------------------------------------
// S_IDLE | waiting for start after reset
// S_WR   | one-cycle write of the current op
// S_RD   | read request; compare here when the memory reads async
// S_CMP  | sync-read data returned; compare at end of cycle
// S_DONE | test finished, results held until next start
module mem_bist #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2,
    parameter int DEPTH      = 4,
    parameter int RD_LAT     = 1,
    parameter int ERR_W      = 8
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  start,
    output logic                  mem_req,
    output logic                  mem_wen,
    output logic                  mem_ren,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [DATA_WIDTH-1:0] fail_exp,
    output logic [DATA_WIDTH-1:0] fail_got,
    output logic [ERR_W-1:0]      err_cnt
);

    import mbist_pkg::*;

    state_t                  state;
    logic [ELEM_W-1:0]       elem;
    logic [ELEM_W-1:0]       elem_nxt;
    logic                    op_idx;
    logic                    op_idx_nxt;
    logic                    cur_wr;
    logic                    cur_bg1;
    logic                    nxt_wr;
    logic [DATA_WIDTH-1:0]   pat;
    logic                    start_ok;
    logic                    cmp_now;
    logic                    op_end;
    logic                    mism;
    logic                    last_op;
    logic                    finish;
    logic                    ag_load;
    logic                    ag_load_down;
    logic                    ag_step;
    logic                    ag_is_last;
    logic [ADDR_WIDTH-1:0]   ag_addr;

`ifdef MBIST_CHECKERBOARD_EN
    logic pass_sel;
    logic pass_sel_nxt;

    function automatic logic [DATA_WIDTH-1:0] chk_base();
        logic [DATA_WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            v[i] = (i % 2 == 0);
        end
        return v;
    endfunction

    localparam logic [DATA_WIDTH-1:0] CHK_B0 = chk_base();
`endif

    mbist_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_addr_gen (
        .clk       (clk),
        .res       (res),
        .load      (ag_load),
        .load_down (ag_load_down),
        .step      (ag_step),
        .dir_down  (ELEM_DOWN[elem]),
        .addr      (ag_addr),
        .is_last   (ag_is_last)
    );

    assign mem_addr = ag_addr;
    // Write data is decoded from registered sequencing state only, so it is
    // stable for the whole WR cycle; the same value is the read expectation.
    assign mem_wr_data = pat;

    // Current op decode, compare, and next-op sequencing through the table.
    always_comb begin
        cur_wr  = OP_IS_WR[{elem, op_idx}];
        cur_bg1 = OP_BG1[{elem, op_idx}];
`ifdef MBIST_CHECKERBOARD_EN
        pat = cur_bg1 ? '1 : '0;
        if (pass_sel) begin
            pat = pat ^ CHK_B0;
            if (ag_addr[0]) begin
                pat = ~pat;
            end
        end
`else
        pat = {DATA_WIDTH{cur_bg1}};
`endif
        start_ok = start && (state == S_IDLE || state == S_DONE);
        cmp_now  = (state == S_CMP) || (state == S_RD && RD_LAT == 0);
        op_end   = (state == S_WR) || cmp_now;
        mism     = cmp_now && !cur_wr && (mem_rd_data != pat);
        last_op  = (op_idx == 1'b1) || !ELEM_TWO_OPS[elem];

        elem_nxt     = elem;
        op_idx_nxt   = op_idx;
        ag_load      = 1'b0;
        ag_load_down = 1'b0;
        ag_step      = 1'b0;
        finish       = 1'b0;
`ifdef MBIST_CHECKERBOARD_EN
        pass_sel_nxt = pass_sel;
`endif
        if (start_ok) begin
            elem_nxt   = '0;
            op_idx_nxt = 1'b0;
            ag_load    = 1'b1;
`ifdef MBIST_CHECKERBOARD_EN
            pass_sel_nxt = 1'b0;
`endif
        end else if (op_end) begin
            if (!last_op) begin
                op_idx_nxt = 1'b1;
            end else begin
                op_idx_nxt = 1'b0;
                if (!ag_is_last) begin
                    ag_step = 1'b1;
                end else if (elem != LAST_ELEM) begin
                    elem_nxt     = elem + ELEM_W'(1);
                    ag_load      = 1'b1;
                    ag_load_down = ELEM_DOWN[elem_nxt];
`ifdef MBIST_CHECKERBOARD_EN
                end else if (!pass_sel) begin
                    pass_sel_nxt = 1'b1;
                    elem_nxt     = '0;
                    ag_load      = 1'b1;
`endif
                end else begin
                    finish = 1'b1;
                end
            end
        end
        nxt_wr = OP_IS_WR[{elem_nxt, op_idx_nxt}];
    end

    // Main FSM with registered port controls, status and error capture.
    always_ff @(posedge clk) begin
        if (res) begin
            state     <= S_IDLE;
            elem      <= '0;
            op_idx    <= 1'b0;
            mem_req   <= 1'b0;
            mem_wen   <= 1'b0;
            mem_ren   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_addr <= '0;
            fail_exp  <= '0;
            fail_got  <= '0;
            err_cnt   <= '0;
`ifdef MBIST_CHECKERBOARD_EN
            pass_sel  <= 1'b0;
`endif
        end else begin
            elem   <= elem_nxt;
            op_idx <= op_idx_nxt;
`ifdef MBIST_CHECKERBOARD_EN
            pass_sel <= pass_sel_nxt;
`endif
            if (mism) begin
                if (err_cnt == '0) begin
                    fail_addr <= ag_addr;
                    fail_exp  <= pat;
                    fail_got  <= mem_rd_data;
                end
                if (err_cnt != '1) begin
                    err_cnt <= err_cnt + ERR_W'(1);
                end
            end
            case (state)
                S_IDLE, S_DONE: begin
                    if (start_ok) begin
                        fail_addr <= '0;
                        fail_exp  <= '0;
                        fail_got  <= '0;
                        err_cnt   <= '0;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        busy      <= 1'b1;
                        mem_req   <= 1'b1;
                        state     <= nxt_wr ? S_WR : S_RD;
                        mem_wen   <= nxt_wr;
                        mem_ren   <= !nxt_wr;
                    end
                end
                default: begin
                    if (state == S_RD && RD_LAT != 0) begin
                        state   <= S_CMP;
                        mem_ren <= 1'b0;
                    end else if (finish) begin
                        state   <= S_DONE;
                        busy    <= 1'b0;
                        mem_req <= 1'b0;
                        mem_wen <= 1'b0;
                        mem_ren <= 1'b0;
                        done    <= 1'b1;
                        pass    <= (err_cnt == '0) && !mism;
                    end else begin
                        state   <= nxt_wr ? S_WR : S_RD;
                        mem_wen <= nxt_wr;
                        mem_ren <= !nxt_wr;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bist.sv
// tb_mem_bist: runs a sync-read (RD_LAT=1) and an async-read (RD_LAT=0)
// instance side by side against stuck-at memory models and a March C-
// reference model.
module tb_mem_bist;

    localparam int DW    = 8;
    localparam int AW    = 2;
    localparam int DEPTH = 4;
    localparam int EW    = 8;
`ifdef MBIST_CHECKERBOARD_EN
    localparam int NPASS = 2;
`else
    localparam int NPASS = 1;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic res   = 1'b1;
    logic start = 1'b0;

    logic          req1, wen1, ren1, busy1, done1, pass1;
    logic [AW-1:0] addr1, fa1;
    logic [DW-1:0] wd1, rd1, fe1, fg1;
    logic [EW-1:0] err1;
    logic          req0, wen0, ren0, busy0, done0, pass0;
    logic [AW-1:0] addr0, fa0;
    logic [DW-1:0] wd0, rd0, fe0, fg0;
    logic [EW-1:0] err0;

    mem_bist #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .RD_LAT(1), .ERR_W(EW)) dut1 (
        .clk(clk), .res(res), .start(start), .mem_req(req1), .mem_wen(wen1), .mem_ren(ren1),
        .mem_addr(addr1), .mem_wr_data(wd1), .mem_rd_data(rd1), .busy(busy1), .done(done1),
        .pass(pass1), .fail_addr(fa1), .fail_exp(fe1), .fail_got(fg1), .err_cnt(err1));

    mem_bist #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .RD_LAT(0), .ERR_W(EW)) dut0 (
        .clk(clk), .res(res), .start(start), .mem_req(req0), .mem_wen(wen0), .mem_ren(ren0),
        .mem_addr(addr0), .mem_wr_data(wd0), .mem_rd_data(rd0), .busy(busy0), .done(done0),
        .pass(pass0), .fail_addr(fa0), .fail_exp(fe0), .fail_got(fg0), .err_cnt(err0));

    // Single stuck-at bit fault, applied to whatever is stored at f_addr.
    bit f_en   = 1'b0;
    int f_addr = 0;
    int f_bit  = 0;
    bit f_val  = 1'b0;

    function automatic logic [DW-1:0] stuck(input logic [DW-1:0] d, input int a);
        if (f_en && a == f_addr) d[f_bit] = f_val;
        return d;
    endfunction

    logic [DW-1:0] ram1 [DEPTH];
    logic [DW-1:0] ram0 [DEPTH];
    logic [DW-1:0] rd1_q;

    always @(posedge clk) begin
        if (wen1) ram1[addr1] <= stuck(wd1, int'(addr1));
        if (ren1) rd1_q <= ram1[addr1];
    end
    assign rd1 = rd1_q;

    always @(posedge clk) begin
        if (wen0) ram0[addr0] <= stuck(wd0, int'(addr0));
    end
    assign rd0 = ram0[addr0];

    // Reference model: walk the March C- notation over an array.
    string el_ops  [6] = '{"w0", "r0w1", "r1w0", "r0w1", "r1w0", "r0"};
    bit    el_down [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    int                m_cyc [2];
    int                m_err;
    int                m_fa;
    logic [DW-1:0]     m_fe, m_fg;
    bit                m_pass;
    logic [AW+DW-1:0]  m_wr_q [$];
    logic [AW+DW-1:0]  wr_log [$];

    int checks   = 0;
    int failures = 0;

    function automatic logic [DW-1:0] bgval(input int p, input bit one, input int a);
        logic [DW-1:0] v;
        if (p == 0) v = one ? 8'hFF : 8'h00;
        else begin
            v = one ? 8'hAA : 8'h55;
            if (a % 2 == 1) v = ~v;
        end
        return v;
    endfunction

    task automatic model_run();
        logic [DW-1:0] mem [DEPTH];
        m_cyc  = '{0, 0};
        m_err  = 0;
        m_fa   = 0;
        m_fe   = '0;
        m_fg   = '0;
        m_wr_q.delete();
        for (int p = 0; p < NPASS; p++)
            for (int e = 0; e < 6; e++)
                for (int i = 0; i < DEPTH; i++) begin
                    int a;
                    a = el_down[e] ? DEPTH - 1 - i : i;
                    for (int k = 0; k < el_ops[e].len() / 2; k++) begin
                        bit is_w, one;
                        logic [DW-1:0] d;
                        is_w = (el_ops[e][2*k] == "w");
                        one  = (el_ops[e][2*k+1] == "1");
                        d    = bgval(p, one, a);
                        if (is_w) begin
                            mem[a] = stuck(d, a);
                            m_wr_q.push_back({a[AW-1:0], d});
                            m_cyc[0] += 1;
                            m_cyc[1] += 1;
                        end else begin
                            m_cyc[0] += 1;
                            m_cyc[1] += 2;
                            if (mem[a] !== d) begin
                                if (m_err == 0) begin
                                    m_fa = a;
                                    m_fe = d;
                                    m_fg = mem[a];
                                end
                                if (m_err < 255) m_err++;
                            end
                        end
                    end
                end
        m_pass = (m_err == 0);
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic snoop();
        if (wen1) wr_log.push_back({addr1, wd1});
    endtask

    // One full test on both instances, checked against the model.
    task automatic run_check(input string tag, input bit poke_busy, output int c1, output int c0);
        int c;
        int bad;
        c   = 0;
        c1  = -1;
        c0  = -1;
        bad = 0;
        model_run();
        wr_log.delete();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        snoop();
        while ((c1 < 0 || c0 < 0) && c < 500) begin
            start = poke_busy && !done1 && !done0 && ($urandom_range(0, 2) == 0);
            @(posedge clk); #1;
            c++;
            snoop();
            if (c1 < 0 && done1) c1 = c;
            if (c0 < 0 && done0) c0 = c;
        end
        start = 1'b0;
        check({tag, ".cyc1"},  c1,    m_cyc[1]);
        check({tag, ".cyc0"},  c0,    m_cyc[0]);
        check({tag, ".pass1"}, pass1, m_pass);
        check({tag, ".pass0"}, pass0, m_pass);
        check({tag, ".err1"},  err1,  m_err);
        check({tag, ".err0"},  err0,  m_err);
        check({tag, ".fa1"},   fa1,   m_fa);
        check({tag, ".fa0"},   fa0,   m_fa);
        check({tag, ".fe1"},   fe1,   m_fe);
        check({tag, ".fe0"},   fe0,   m_fe);
        check({tag, ".fg1"},   fg1,   m_fg);
        check({tag, ".fg0"},   fg0,   m_fg);
        check({tag, ".idle"},  {busy1, req1, busy0, req0, wen1, ren1, wen0, ren0}, 8'h00);
        check({tag, ".wr_len"}, wr_log.size(), m_wr_q.size());
        for (int i = 0; i < wr_log.size() && i < m_wr_q.size(); i++)
            if (wr_log[i] !== m_wr_q[i]) bad++;
        check({tag, ".wr_trace"}, bad, 0);
    endtask

    initial begin
        int c1, c0, ab;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst.dut1", {req1, wen1, ren1, addr1, wd1, busy1, done1, pass1, fa1, fe1, fg1, err1}, 64'h0);
        check("rst.dut0", {req0, wen0, ren0, addr0, wd0, busy0, done0, pass0, fa0, fe0, fg0, err0}, 64'h0);

        // res and start together: res wins
        start = 1'b1;
        @(posedge clk); #1;
        check("res_vs_start", {busy1, req1, busy0, req0}, 4'h0);
        res   = 1'b0;
        start = 1'b0;

        // Fault-free, directed cycle counts
        f_en = 1'b0;
        run_check("clean", 1'b0, c1, c0);
        check("clean.cyc1_abs", c1, 60 * NPASS);
        check("clean.cyc0_abs", c0, 40 * NPASS);
`ifdef MBIST_CHECKERBOARD_EN
        begin
            logic [AW+DW-1:0] w20, w21;
            w20 = (wr_log.size() > 21) ? wr_log[20] : 'x;
            w21 = (wr_log.size() > 21) ? wr_log[21] : 'x;
            check("chk.addr0_55", w20, {2'd0, 8'h55});
            check("chk.addr1_aa", w21, {2'd1, 8'hAA});
        end
`endif

        // Stuck-at-0 bit 3 at address 2
        f_en = 1'b1; f_addr = 2; f_bit = 3; f_val = 1'b0;
        run_check("sa0", 1'b0, c1, c0);
        check("sa0.first1", {pass1, fa1, fe1, fg1}, {1'b0, 2'd2, 8'hFF, 8'hF7});
        check("sa0.first0", {pass0, fa0, fe0, fg0}, {1'b0, 2'd2, 8'hFF, 8'hF7});
        check("sa0.err_abs", err1, 2 * NPASS);

        // Stuck-at-1 bit 0 at address 1: caught first in E1
        f_en = 1'b1; f_addr = 1; f_bit = 0; f_val = 1'b1;
        run_check("sa1", 1'b1, c1, c0);
        check("sa1.first1", {pass1, fa1, fe1, fg1}, {1'b0, 2'd1, 8'h00, 8'h01});
        check("sa1.first0", {pass0, fa0, fe0, fg0}, {1'b0, 2'd1, 8'h00, 8'h01});

        // Reset mid-test at cycle 20, then at a random cycle
        f_en = 1'b0;
        for (int r = 0; r < 2; r++) begin
            ab = (r == 0) ? 20 : $urandom_range(2, 38);
            @(posedge clk); #1;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            repeat (ab - 1) begin
                @(posedge clk); #1;
            end
            check("abort.busy_before", {busy1, busy0}, 2'b11);
            res = 1'b1;
            @(posedge clk); #1;
            check("abort.after", {busy1, wen1, ren1, req1, done1, busy0, wen0, ren0, req0, done0}, 10'h0);
            res = 1'b0;
            run_check("after_abort", 1'b1, c1, c0);
        end

        // Randomised faults and start pokes while busy
        for (int t = 0; t < 8; t++) begin
            f_en   = ($urandom_range(0, 4) != 0);
            f_addr = $urandom_range(0, DEPTH - 1);
            f_bit  = $urandom_range(0, DW - 1);
            f_val  = $urandom_range(0, 1);
            run_check("rand", $urandom_range(0, 1), c1, c0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_bist.md
Name: mem_bist

Overview:
- Built-in self-test controller that sits directly upstream of the `memory` block and drives its write/read port.
- Runs a March C- sequence over every address and compares read data against the expected pattern.
- Reports pass/fail, the first failing location and a saturating error count.
- Replaces ad-hoc bench stimulus with synthesizable self-test for both the single-cycle core's data memory and standalone RAM instances.

Parameters:
- DATA_WIDTH, 8, width of memory data word.
- ADDR_WIDTH, 2, memory address width.
- DEPTH, 4, number of words tested (addresses 0..DEPTH-1, DEPTH <= 2**ADDR_WIDTH).
- RD_LAT, 1, memory read latency in cycles (0 = async read, 1 = sync read); only 0 and 1 are legal.
- ERR_W, 8, width of the error counter.

Ports:
- clk  in  1  single clock; also drives memory wclk and rclk.
- res  in  1  synchronous active-high reset.
- start  in  1  begin test; sampled in IDLE or DONE only.
- mem_req  out  1  memory request, high while busy.
- mem_wen  out  1  memory write enable.
- mem_ren  out  1  memory read enable.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wr_data  out  DATA_WIDTH  write data.
- mem_rd_data  in  DATA_WIDTH  read data returned by memory.
- busy  out  1  test in progress.
- done  out  1  test finished; level, held until next start or res.
- pass  out  1  valid when done: 1 = zero mismatches.
- fail_addr  out  ADDR_WIDTH  address of first mismatch.
- fail_exp  out  DATA_WIDTH  expected data at first mismatch.
- fail_got  out  DATA_WIDTH  read data at first mismatch.
- err_cnt  out  ERR_W  mismatch count, saturates at all-ones.

Behaviour:
- Reset: all outputs 0; state IDLE. A reset mid-test aborts immediately; mem_wen and mem_ren are low from the next edge.
- March C- elements, using background B0 = 0 and B1 = all-ones:
  - E0 any(w0)
  - E1 up(r0,w1)
  - E2 up(r1,w0)
  - E3 down(r0,w1)
  - E4 down(r1,w0)
  - E5 any(r0)
  - "any" is executed ascending.
- States: IDLE, WR, RD, CMP, DONE.
- Start: start=1 in IDLE/DONE clears the fail_* registers, err_cnt and done, then enters the first op of E0 on the next edge. start while busy is ignored.
- WR: one cycle; mem_wen=1 with mem_addr and mem_wr_data stable for that whole cycle; mem_ren=0.
- RD: mem_ren=1 for one cycle.
  - RD_LAT=0: mem_rd_data is compared at the end of the RD cycle; there is no CMP state.
  - RD_LAT=1: CMP follows for one cycle with mem_ren=0; the compare happens at the end of CMP.
- Compare: a mismatch increments err_cnt (saturating). On the first mismatch only, capture fail_addr, fail_exp and fail_got. The test continues to completion.
- Addressing: ascending runs 0..DEPTH-1; descending runs DEPTH-1..0. At the terminal address of an element, advance to the next element and load its start address. No wrap beyond DEPTH-1.
- Completion: after the last E5 op, enter DONE. busy=0, done=1, pass=(err_cnt==0), mem_req=0.
- Cycle count, start-sampling edge to done=1, for DEPTH=4:
  - RD_LAT=1: 60 cycles.
  - RD_LAT=0: 40 cycles.
  - General: DEPTH*(1 + 4*(2+RD_LAT) + (1+RD_LAT)).
- Memory sizing: the memory's mem_size is tied to full-word byte op 3'b000 externally and zero_ex to 0. This block does not drive them.
- Simultaneous res and start: res wins.

Optional Feature:
- Macro: MBIST_CHECKERBOARD_EN.
- Defined: after the solid pass, a second full March C- pass runs with B0 = alternating 0101..., B1 = its complement. Per-address polarity is inverted on odd addresses. The cycle count doubles (120 for DEPTH=4, RD_LAT=1). fail_* still captures the first mismatch across both passes.
- Undefined: solid pass only, with no extra logic.

Decomposition:
- Package mbist_pkg holds:
  - state enum (IDLE, WR, RD, CMP, DONE);
  - element table constants: per element a direction bit, op count, and op list (read/write plus background select);
  - NUM_ELEM = 6.
- Sub-module mbist_addr_gen: loadable up/down address counter with an is_last flag for ascending/descending termination. It is instantiated once.

Test Plan:
- Fault-free memory, DEPTH=4, RD_LAT=1, start pulse: done rises exactly 60 cycles later, pass=1, err_cnt=0, fail_* = 0.
- Memory model with bit 3 of address 2 stuck-at-0: pass=0, fail_addr=2, fail_exp=8'hFF, fail_got=8'hF7, err_cnt=2.
- Stuck-at-1 bit 0 at address 1: first failure is in E1, so fail_addr=1, fail_exp=8'h00, fail_got=8'h01.
- res asserted on cycle 20 of a test: next edge busy=0, mem_wen=0, mem_ren=0. A later start runs the full 60 cycles and passes.
- RD_LAT=0 with an async-read memory: done after 40 cycles, pass=1. start pulses while busy do not alter the cycle count.
- With MBIST_CHECKERBOARD_EN and DEPTH=4: 120 cycles. Address 0 is first written 8'h55 in the second pass, address 1 is written 8'hAA; pass=1.
